// File: rtl/car_sequencer.sv
// car_sequencer: MSP430 microsequencer producing the control address register (CAR)
// Ports: MCLK clock, RST_n async active-low reset, InstrIn fetched word (used in CAR_0),
//        Flags {V,N,Z,C}, GIE, INTREQ level irq, Stall freeze, CAR state code, InstrDone pulse
module car_sequencer #(
    parameter int CAR_BITS = 6
) (
    input  logic                MCLK,
    input  logic                RST_n,
    input  logic [15:0]         InstrIn,
    input  logic [3:0]          Flags,
    input  logic                GIE,
    input  logic                INTREQ,
    input  logic                Stall,
    output logic [CAR_BITS-1:0] CAR,
    output logic                InstrDone
);
    typedef enum logic [CAR_BITS-1:0] {
        s_car0,
        s_reg_reg,
        s_reg_idx[4],
        s_ind_reg[2],
        s_ind_idx[5],
        s_idx_reg[3],
        s_idx_idx[6],
        s_op1_reg,
        s_op1_ind[3],
        s_op1_idx[4],
        s_push_reg[3],
        s_push_ind[3],
        s_push_idx[4],
        s_call_reg[3],
        s_call_ind[3],
        s_call_idx[4],
        s_reti[4],
        s_int[5],
        s_jmp0
    } state_t;
    typedef enum logic [1:0] {m_reg, m_ind, m_idx} mode_t;
    state_t state, nxt;
    logic   term;
    mode_t  src_mode, dst_mode;
    logic   unused_bw;
    function automatic mode_t op_mode(input logic [3:0] r, input logic [1:0] as);
        return (as == 2'b00 || r == 4'd3 || (r == 4'd2 && as[1])) ? m_reg : as[1] ? m_ind : m_idx;
    endfunction
    function automatic state_t pick(input mode_t m, input state_t r, input state_t i, input state_t x);
        return m == m_reg ? r : m == m_ind ? i : x;
    endfunction
    function automatic logic jump_taken(input logic [2:0] c, input logic [3:0] f);
        logic [7:0] t;
        t = {1'b1, f[2] ^ f[3], ~(f[2] ^ f[3]), f[2], f[0], ~f[0], f[1], ~f[1]};
        return t[c];
    endfunction
    assign src_mode  = op_mode(InstrIn[11:8], InstrIn[5:4]);
    assign dst_mode  = op_mode(InstrIn[3:0], InstrIn[5:4]);
    assign unused_bw = InstrIn[6];
    assign CAR       = state;
    // RST_n gating keeps the pulse low during reset even if CAR_0 sees an illegal word
    assign InstrDone = term & RST_n;
    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) state <= s_car0;
        else        state <= nxt;
    end
    always_comb begin
        nxt  = s_car0;
        term = 1'b0;
        if (state == s_car0) begin
            if (InstrIn[15:13] == 3'b001) begin
                if (jump_taken(InstrIn[12:10], Flags)) nxt = s_jmp0;
                else term = 1'b1;
            end else if (InstrIn[15:10] == 6'b000100) begin
                case (InstrIn[9:7])
                    3'b100:  nxt = pick(dst_mode, s_push_reg0, s_push_ind0, s_push_idx0);
                    3'b101:  nxt = pick(dst_mode, s_call_reg0, s_call_ind0, s_call_idx0);
                    3'b110:  nxt = s_reti0;
                    3'b111:  term = 1'b1;
                    default: nxt = pick(dst_mode, s_op1_reg, s_op1_ind0, s_op1_idx0);
                endcase
            end else if (InstrIn[15:14] != 2'b00) begin
                nxt = InstrIn[7] ? pick(src_mode, s_reg_idx0, s_ind_idx0, s_idx_idx0)
                                 : pick(src_mode, s_reg_reg, s_ind_reg0, s_idx_reg0);
            end else begin
                term = 1'b1;
            end
        end else if (state == s_int4) begin
            nxt = s_car0;
        end else if (state inside {s_reg_reg, s_reg_idx3, s_ind_reg1, s_ind_idx4, s_idx_reg2,
                                   s_idx_idx5, s_op1_reg, s_op1_ind2, s_op1_idx3, s_push_reg2,
                                   s_push_ind2, s_push_idx3, s_call_reg2, s_call_ind2,
                                   s_call_idx3, s_reti3, s_jmp0}) begin
            term = 1'b1;
        end else if (state < s_jmp0) begin
            nxt = state_t'(state + 1'b1);
        end
        // INT4 never enters here, so one instruction runs between back-to-back interrupts
        if (term) nxt = (INTREQ & GIE) ? s_int0 : s_car0;
        if (Stall) begin
            nxt  = state;
            term = 1'b0;
        end
    end
endmodule

// File: tb/tb_car_sequencer.sv
// tb_car_sequencer: directed and random checks of car_sequencer against a chain-table model
module tb_car_sequencer;
    logic        MCLK = 1'b0;
    logic        RST_n;
    logic [15:0] InstrIn;
    logic [3:0]  Flags;
    logic        GIE, INTREQ, Stall;
    logic [5:0]  CAR;
    logic        InstrDone;
    int n_cmp = 0;
    int n_err = 0;
    int m_car = 0;
    int len[19] = '{1, 1, 4, 2, 5, 3, 6, 1, 3, 4, 3, 3, 4, 3, 3, 4, 4, 5, 1};
    int start[19];
    car_sequencer #(.CAR_BITS(6)) dut (
        .MCLK(MCLK), .RST_n(RST_n), .InstrIn(InstrIn), .Flags(Flags), .GIE(GIE),
        .INTREQ(INTREQ), .Stall(Stall), .CAR(CAR), .InstrDone(InstrDone)
    );
    always #5 MCLK = ~MCLK;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int mode_of(input logic [3:0] r, input logic [1:0] as);
        if (as == 2'd0 || r == 4'd3 || (r == 4'd2 && as >= 2'd2)) return 0;
        return (as == 2'd1) ? 2 : 1;
    endfunction
    function automatic bit jcond(input logic [2:0] c, input logic [3:0] f);
        bit v, n, z, cy;
        {v, n, z, cy} = f;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !cy;
            3'd3: return cy;
            3'd4: return n;
            3'd5: return n == v;
            3'd6: return n != v;
            default: return 1'b1;
        endcase
    endfunction
    task automatic model_step(input int car, input logic [15:0] w, input logic [3:0] f,
                              input bit g, input bit q, input bit s, output int nx, output bit d);
        int  k;
        bit  fin, is_last;
        k = -1; fin = 0; d = 0; nx = 0;
        if (s) begin
            nx = car;
            return;
        end
        if (car == 0) begin
            if (w[15:13] == 3'b001) begin
                if (jcond(w[12:10], f)) k = 18; else fin = 1;
            end else if (w[15:10] == 6'b000100) begin
                case (int'(w[9:7]))
                    0, 1, 2, 3: k = 7 + mode_of(w[3:0], w[5:4]);
                    4: k = 10 + mode_of(w[3:0], w[5:4]);
                    5: k = 13 + mode_of(w[3:0], w[5:4]);
                    6: k = 16;
                    default: fin = 1;
                endcase
            end else if (w[15:12] >= 4'd4) begin
                k = 1 + 2 * mode_of(w[11:8], w[5:4]) + int'(w[7]);
            end else begin
                fin = 1;
            end
            if (k >= 0) nx = start[k];
        end else begin
            is_last = 0;
            for (int c = 1; c < 19; c++)
                if (car == start[c] + len[c] - 1) begin
                    is_last = 1;
                    if (c != 17) fin = 1;
                end
            if (!is_last) nx = (car < 60) ? car + 1 : 0;
        end
        if (fin) begin
            d  = 1;
            nx = (g && q) ? start[17] : 0;
        end
    endtask
    task automatic cycle(input logic [15:0] w, input logic [3:0] f, input bit g, input bit q, input bit s);
        int nx;
        bit d;
        InstrIn = w; Flags = f; GIE = g; INTREQ = q; Stall = s;
        @(negedge MCLK);
        model_step(m_car, w, f, g, q, s, nx, d);
        chk("car", 8'(CAR), 8'(m_car));
        chk("done", 8'(InstrDone), 8'(d));
        @(posedge MCLK);
        #1;
        m_car = nx;
    endtask
    initial begin
        logic [15:0] w;
        start[0] = 0;
        for (int k = 1; k < 19; k++) start[k] = start[k-1] + len[k-1];
        RST_n = 1'b0; InstrIn = 16'h0123; Flags = 4'h0; GIE = 1'b0; INTREQ = 1'b0; Stall = 1'b0;
        repeat (2) @(posedge MCLK);
        #1;
        chk("rst_car", 8'(CAR), 8'd0);
        chk("rst_done", 8'(InstrDone), 8'd0);
        RST_n = 1'b1;
        m_car = 0;
        cycle(16'h4A0B, 4'h0, 0, 0, 0);
        chk("mov_entry", 8'(CAR), 8'd1);
        cycle(16'h4A0B, 4'h0, 0, 0, 0);
        chk("mov_back", 8'(CAR), 8'd0);
        cycle(16'h5C9D, 4'h0, 0, 0, 0);
        chk("add_entry", 8'(CAR), 8'd16);
        for (int i = 0; i < 3; i++) cycle(16'h5C9D, 4'h0, 0, 0, 0);
        cycle(16'h5C9D, 4'h0, 0, 0, 1);
        cycle(16'h5C9D, 4'h0, 0, 0, 1);
        chk("stall_hold", 8'(CAR), 8'd19);
        for (int i = 0; i < 3; i++) cycle(16'h5C9D, 4'h0, 0, 0, 0);
        chk("add_end", 8'(CAR), 8'd0);
        for (int i = 0; i < 3; i++) cycle(16'h5C9D, 4'h0, 0, 0, 0);
        chk("pre_rst", 8'(CAR), 8'd18);
        InstrIn = 16'h0123;
        #2 RST_n = 1'b0;
        #1;
        chk("async_rst_car", 8'(CAR), 8'd0);
        chk("async_rst_done", 8'(InstrDone), 8'd0);
        @(posedge MCLK);
        #1;
        RST_n = 1'b1;
        m_car = 0;
        cycle(16'h4A0B, 4'h0, 0, 0, 0);
        cycle(16'h4A0B, 4'h0, 0, 0, 0);
        cycle(16'h2400, 4'b0010, 0, 0, 0);
        chk("jeq_taken", 8'(CAR), 8'd59);
        cycle(16'h2400, 4'b0010, 0, 0, 0);
        cycle(16'h2400, 4'b0000, 0, 0, 0);
        chk("jeq_not", 8'(CAR), 8'd0);
        cycle(16'h1230, 4'h0, 0, 0, 0);
        chk("push_entry", 8'(CAR), 8'd33);
        cycle(16'h1230, 4'h0, 0, 0, 0);
        cycle(16'h1230, 4'h0, 1, 1, 0);
        cycle(16'h1230, 4'h0, 1, 1, 0);
        chk("push_irq", 8'(CAR), 8'd54);
        for (int i = 0; i < 5; i++) cycle(16'h4A0B, 4'h0, 1, 1, 0);
        chk("int_exit", 8'(CAR), 8'd0);
        cycle(16'h4A0B, 4'h0, 1, 1, 0);
        chk("after_int", 8'(CAR), 8'd1);
        cycle(16'h4A0B, 4'h0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(16'h0123, 4'h0, 0, 0, 0);
        cycle(16'h1300, 4'h0, 1, 1, 0);
        chk("reti_entry", 8'(CAR), 8'd50);
        for (int i = 0; i < 4; i++) cycle(16'h1300, 4'h0, 1, 1, 0);
        chk("reti_irq", 8'(CAR), 8'd54);
        for (int i = 0; i < 5; i++) cycle(16'h0123, 4'h0, 0, 0, 0);
        cycle(16'h0123, 4'h0, 0, 0, 0);
        chk("illegal_stay", 8'(CAR), 8'd0);
        for (int i = 0; i < 3000; i++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w[15:13] = 3'b001;
                1: w[15:10] = 6'b000100;
                default: ;
            endcase
            cycle(w, 4'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
